// File: rtl/dma_lite_copy_engine.sv
// AXI4-Lite word copy engine: reads one word from the source range, writes it
// to the destination range, and repeats until the command length is done.
// Only one AXI transaction is in flight at a time, and every AXI output is registered.
module dma_lite_copy_engine #(
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [LEN_WIDTH-1:0]  len_words,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [31:0]           m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [ADDR_W-1:0] WORD_BYTES = 32'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     src_q, src_d;
  logic [ADDR_W-1:0]     dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;

  logic                  busy_d, done_d, error_d;
  logic [LEN_WIDTH-1:0]  words_done_d;
  logic [ADDR_W-1:0]     araddr_d, awaddr_d;
  logic                  arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Write-channel handshakes that are still outstanding after this edge
  logic aw_pending, w_pending;
  assign aw_pending = m_axi_awvalid && !m_axi_awready;
  assign w_pending  = m_axi_wvalid  && !m_axi_wready;

  // Strobes are always full-word
  assign m_axi_wstrb = 4'hF;

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    busy_d       = busy;
    done_d       = 1'b0;
    error_d      = error;
    words_done_d = words_done;
    araddr_d     = m_axi_araddr;
    arvalid_d    = m_axi_arvalid;
    rready_d     = m_axi_rready;
    awaddr_d     = m_axi_awaddr;
    awvalid_d    = m_axi_awvalid;
    wdata_d      = m_axi_wdata;
    wvalid_d     = m_axi_wvalid;
    bready_d     = m_axi_bready;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = src_addr & WORD_MASK;
          dst_d        = dst_addr & WORD_MASK;
          rem_d        = len_words;
          words_done_d = '0;
          error_d      = 1'b0;
          if (len_words == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            busy_d    = 1'b1;
            arvalid_d = 1'b1;
            araddr_d  = src_addr & WORD_MASK;
          end
        end
      end

      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          wdata_d  = m_axi_rdata;
          if (m_axi_rresp != 2'b00) begin
            error_d = 1'b1;
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            awaddr_d  = dst_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end
        end
      end

      WR: begin
        // AW and W retire independently; move on once neither is pending
        awvalid_d = aw_pending;
        wvalid_d  = w_pending;
        if (!aw_pending && !w_pending) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            error_d = 1'b1;
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            words_done_d = words_done + LEN_WIDTH'(1);
            src_d        = src_q + WORD_BYTES;
            dst_d        = dst_q + WORD_BYTES;
            rem_d        = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = FINISH;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d   = RD_ADDR;
              arvalid_d = 1'b1;
              araddr_d  = src_q + WORD_BYTES;
            end
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_done    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      rem_q         <= rem_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
      words_done    <= words_done_d;
      m_axi_araddr  <= araddr_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
    end
  end

endmodule

// File: tb/tb_dma_lite_copy_engine.sv
// Bench for dma_lite_copy_engine: an AXI4-Lite memory slave with programmable
// per-channel delays and injectable error responses, plus a copy-level
// reference model that predicts the read/write traffic and the final status.
module tb_dma_lite_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        busy, done, error;
  logic [15:0] words_done;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  dma_lite_copy_engine #(.LEN_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Contents of any word never written
  function automatic logic [31:0] mem_init(input logic [29:0] k);
    return {2'b00, k} ^ 32'h5EED_1234;
  endfunction

  // Slave state and configuration
  logic [31:0] smem [logic [29:0]];
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int rd_err_idx = -1, wr_err_idx = -1;
  int rd_cnt = 0, wr_cnt = 0;
  logic [31:0] rd_log[$], wa_log[$], wd_log[$];
  int done_cnt = 0, act_cnt = 0, viol_cnt = 0;

  // Reference model state
  logic [31:0] mmem [logic [29:0]];
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
  bit          exp_err;
  int          exp_words;

  // Sequential word-by-word copy with early stop on an injected error
  task automatic model_cmd(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int rde, input int wre);
    logic [31:0] sa, da, a, w, v;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    exp_err = 1'b0; exp_words = 0;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      a = sa + 32'(4 * i);
      w = da + 32'(4 * i);
      exp_rd.push_back(a);
      if (i == rde) begin exp_err = 1'b1; break; end
      v = mmem.exists(a[31:2]) ? mmem[a[31:2]] : mem_init(a[31:2]);
      exp_wa.push_back(w);
      exp_wd.push_back(v);
      if (i == wre) begin exp_err = 1'b1; break; end
      mmem[w[31:2]] = v;
      exp_words = i + 1;
    end
  endtask

  // AXI4-Lite slave: samples handshakes at negedge, updates just after posedge
  logic        s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs, s_aw_got, s_w_got, s_r_pend, s_b_pend;
  logic        s_ar_wait, s_aw_wait, s_w_wait;
  logic [31:0] s_ar_a, s_aw_a, s_w_d, s_got_aw, s_got_w, s_hold_ar, s_hold_aw, s_hold_w;
  logic [1:0]  s_bresp_nx;
  int          s_ar_c, s_r_c, s_aw_c, s_w_c, s_b_c;
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    s_aw_got = 0; s_w_got = 0; s_r_pend = 0; s_b_pend = 0; s_bresp_nx = 0;
    s_ar_wait = 0; s_aw_wait = 0; s_w_wait = 0;
    s_ar_c = 0; s_r_c = 0; s_aw_c = 0; s_w_c = 0; s_b_c = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (s_ar_wait && !(m_axi_arvalid && m_axi_araddr == s_hold_ar)) viol_cnt++;
        if (s_aw_wait && !(m_axi_awvalid && m_axi_awaddr == s_hold_aw)) viol_cnt++;
        if (s_w_wait && !(m_axi_wvalid && m_axi_wdata == s_hold_w)) viol_cnt++;
        if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid)) viol_cnt++;
        if (m_axi_wvalid && m_axi_wstrb != 4'hF) viol_cnt++;
      end
      s_ar_wait = rst_n && m_axi_arvalid && !m_axi_arready;
      s_aw_wait = rst_n && m_axi_awvalid && !m_axi_awready;
      s_w_wait  = rst_n && m_axi_wvalid && !m_axi_wready;
      s_hold_ar = m_axi_araddr; s_hold_aw = m_axi_awaddr; s_hold_w = m_axi_wdata;
      s_ar_hs = m_axi_arvalid && m_axi_arready;
      s_r_hs  = m_axi_rvalid && m_axi_rready;
      s_aw_hs = m_axi_awvalid && m_axi_awready;
      s_w_hs  = m_axi_wvalid && m_axi_wready;
      s_b_hs  = m_axi_bvalid && m_axi_bready;
      s_ar_a = m_axi_araddr; s_aw_a = m_axi_awaddr; s_w_d = m_axi_wdata;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        s_aw_got = 0; s_w_got = 0; s_r_pend = 0; s_b_pend = 0;
        s_ar_c = 0; s_aw_c = 0; s_w_c = 0;
        continue;
      end
      if (s_ar_hs) begin
        m_axi_arready = 0; s_ar_c = 0;
        rd_log.push_back(s_ar_a);
        m_axi_rdata = smem.exists(s_ar_a[31:2]) ? smem[s_ar_a[31:2]] : mem_init(s_ar_a[31:2]);
        m_axi_rresp = (rd_cnt == rd_err_idx) ? 2'b10 : 2'b00;
        rd_cnt++;
        s_r_pend = 1; s_r_c = 0;
      end
      if (s_r_hs) m_axi_rvalid = 0;
      if (s_aw_hs) begin m_axi_awready = 0; s_aw_c = 0; s_aw_got = 1; s_got_aw = s_aw_a; end
      if (s_w_hs)  begin m_axi_wready = 0;  s_w_c = 0;  s_w_got = 1;  s_got_w = s_w_d;   end
      if (s_aw_got && s_w_got) begin
        s_aw_got = 0; s_w_got = 0;
        wa_log.push_back(s_got_aw);
        wd_log.push_back(s_got_w);
        if (wr_cnt == wr_err_idx) s_bresp_nx = 2'b10;
        else begin s_bresp_nx = 2'b00; smem[s_got_aw[31:2]] = s_got_w; end
        wr_cnt++;
        s_b_pend = 1; s_b_c = 0;
      end
      if (s_b_hs) m_axi_bvalid = 0;
      if (m_axi_arvalid && !m_axi_arready) begin
        if (s_ar_c >= ar_dly) m_axi_arready = 1; else s_ar_c++;
      end
      if (m_axi_awvalid && !m_axi_awready && !s_aw_got) begin
        if (s_aw_c >= aw_dly) m_axi_awready = 1; else s_aw_c++;
      end
      if (m_axi_wvalid && !m_axi_wready && !s_w_got) begin
        if (s_w_c >= w_dly) m_axi_wready = 1; else s_w_c++;
      end
      if (s_r_pend) begin
        if (s_r_c >= r_dly) begin m_axi_rvalid = 1; s_r_pend = 0; end else s_r_c++;
      end
      if (s_b_pend) begin
        if (s_b_c >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = s_bresp_nx; s_b_pend = 0; end
        else s_b_c++;
      end
    end
  end

  // Done pulses and any master-side channel activity
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid || m_axi_rready || m_axi_bready) act_cnt++;
    end
  end

  // Issue one command and compare the whole outcome with the model
  task automatic run_cmd(input string tag, input logic [31:0] s, input logic [31:0] d,
                         input int n, input int rde, input int wre, input bit restart);
    int cyc;
    int busy_bad;
    model_cmd(s, d, n, rde, wre);
    rd_err_idx = rde; wr_err_idx = wre; rd_cnt = 0; wr_cnt = 0;
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    @(negedge clk);
    done_cnt = 0; act_cnt = 0; viol_cnt = 0;
    start = 1'b1; src_addr = s; dst_addr = d; len_words = 16'(n);
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len_words = 16'($urandom);
    check_eq($sformatf("%s:clr", tag), 64'({error, words_done}), 64'd0);
    cyc = 0; busy_bad = 0;
    while (!done && cyc < 3000) begin
      if (!busy) busy_bad++;
      if (restart && cyc == 2) begin
        start = 1'b1; src_addr = 32'h0000_4440; dst_addr = 32'h0000_5550; len_words = 16'd9;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq($sformatf("%s:done", tag), 64'(done), 64'd1);
    if (n == 0) check_eq($sformatf("%s:len0_lat", tag), 64'(cyc), 64'd0);
    check_eq($sformatf("%s:busy_end", tag), 64'(busy), 64'd0);
    check_eq($sformatf("%s:busy_run", tag), 64'(busy_bad), 64'd0);
    check_eq($sformatf("%s:error", tag), 64'(error), 64'(exp_err));
    check_eq($sformatf("%s:words", tag), 64'(words_done), 64'(exp_words));
    @(negedge clk);
    check_eq($sformatf("%s:pulses", tag), 64'(done_cnt), 64'd1);
    check_eq($sformatf("%s:nrd", tag), 64'(rd_log.size()), 64'(exp_rd.size()));
    check_eq($sformatf("%s:nwr", tag), 64'(wa_log.size()), 64'(exp_wa.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check_eq($sformatf("%s:ar%0d", tag, i), 64'(rd_log[i]), 64'(exp_rd[i]));
    for (int i = 0; i < exp_wa.size() && i < wa_log.size(); i++) begin
      check_eq($sformatf("%s:aw%0d", tag, i), 64'(wa_log[i]), 64'(exp_wa[i]));
      check_eq($sformatf("%s:wd%0d", tag, i), 64'(wd_log[i]), 64'(exp_wd[i]));
    end
    check_eq($sformatf("%s:proto", tag), 64'(viol_cnt), 64'd0);
    if (n == 0) check_eq($sformatf("%s:no_traffic", tag), 64'(act_cnt), 64'd0);
  endtask

  task automatic set_dly(input int ar, input int r, input int aw, input int w, input int b);
    ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  // Directed scenarios followed by randomized commands
  initial begin
    int n, rde, wre, cyc;
    logic [31:0] k;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", 64'({busy, done, error, words_done, m_axi_arvalid, m_axi_awvalid,
                                m_axi_wvalid, m_axi_rready, m_axi_bready}), 64'd0);
    check_eq("reset_addr", {m_axi_araddr, m_axi_awaddr}, 64'd0);
    check_eq("reset_wdata", 64'(m_axi_wdata), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      smem[30'(i)] = 32'hA0 + 32'(i);
      mmem[30'(i)] = 32'hA0 + 32'(i);
    end
    set_dly(0, 0, 0, 0, 0);
    run_cmd("basic", 32'h0, 32'h100, 4, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      k = 32'h40 + 32'(i);
      check_eq($sformatf("basic:mem%0d", i), 64'(smem.exists(k[29:0]) ? smem[k[29:0]] : 32'h0),
               64'(32'hA0 + 32'(i)));
    end

    run_cmd("len0", 32'h40, 32'h80, 0, -1, -1, 1'b0);

    set_dly(0, 0, 3, 0, 0);
    run_cmd("aw_slow", 32'h300, 32'h400, 3, -1, -1, 1'b0);
    set_dly(0, 0, 0, 3, 0);
    run_cmd("w_slow", 32'h310, 32'h410, 3, -1, -1, 1'b0);

    set_dly(1, 1, 0, 0, 1);
    run_cmd("berr", 32'h500, 32'h600, 5, -1, 1, 1'b0);
    run_cmd("after_berr", 32'h700, 32'h780, 2, -1, -1, 1'b0);
    run_cmd("rerr", 32'h800, 32'h880, 4, 2, -1, 1'b0);

    set_dly(0, 2, 1, 1, 0);
    run_cmd("restart", 32'h900, 32'hA00, 6, -1, -1, 1'b1);

    // Reset while the engine waits for read data
    set_dly(0, 8, 0, 0, 0);
    rd_err_idx = -1; wr_err_idx = -1;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h200; dst_addr = 32'h280; len_words = 16'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!m_axi_rready && cyc < 50) begin @(negedge clk); cyc++; end
    check_eq("rst_reach_rd", 64'(m_axi_rready), 64'd1);
    done_cnt = 0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", 64'({busy, done, error, words_done, m_axi_arvalid, m_axi_awvalid,
                                  m_axi_wvalid, m_axi_rready, m_axi_bready}), 64'd0);
    check_eq("rst_mid_addr", {m_axi_araddr, m_axi_awaddr}, 64'd0);
    check_eq("rst_mid_wdata", 64'(m_axi_wdata), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_mid_nodone", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_dly(0, 0, 0, 0, 0);
    run_cmd("wrap", 32'hFFFF_FFF8, 32'h800, 3, -1, -1, 1'b0);
    if (rd_log.size() == 3) check_eq("wrap:ar2_zero", 64'(rd_log[2]), 64'd0);
    else check_eq("wrap:ar_count", 64'(rd_log.size()), 64'd3);
    run_cmd("misalign", 32'h103, 32'hC02, 1, -1, -1, 1'b0);
    if (rd_log.size() >= 1) check_eq("misalign:ar0", 64'(rd_log[0]), 64'h100);
    else check_eq("misalign:ar_count", 64'(rd_log.size()), 64'd1);

    for (int t = 0; t < 25; t++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      rde = -1; wre = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) rde = $urandom_range(0, n - 1);
        else wre = $urandom_range(0, n - 1);
      end
      run_cmd($sformatf("rnd%0d", t), $urandom, $urandom, n, rde, wre, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global guard against a stalled run
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
